// File: rtl/hit_scorer.sv
// hit_scorer: turns judge hits and enemy lane position into score, combo, lives and a timed judgement flag
module hit_scorer #(
   parameter logic [3:0] HIT_WINDOW     = 4'd3,
   parameter logic [3:0] PERFECT_MAX    = 4'd1,
   parameter logic [7:0] COMBO_BONUS_AT = 8'd10,
   parameter logic [2:0] LIVES          = 3'd3,
   parameter int         FLAG_HOLD      = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hit,
   input  logic [3:0]  pos,
   output logic [15:0] score_bcd,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo,
   output logic [2:0]  lives,
   output logic        game_over,
   output logic [1:0]  judge_flag
);
   localparam int CW = $clog2(FLAG_HOLD + 1);
   localparam logic [CW-1:0] LOAD = CW'(FLAG_HOLD - 1);
   logic [3:0] pos_m, pos_s, pos_q, cpos;
   logic hit_q, credited, armed;
   logic rise, respawn, credit, miss, perfect;
   logic [2:0] points;
   logic [7:0] combo_n;
   logic [CW-1:0] cnt;

   function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [2:0] p);
      logic [15:0] r;
      logic [4:0] t;
      logic cy;
      r = s;
      cy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t = {1'b0, s[4*i +: 4]} + ((i == 0) ? {2'b0, p} : {4'b0, cy});
         cy = t > 5'd9;
         r[4*i +: 4] = cy ? t[3:0] - 4'd10 : t[3:0];
      end
      return cy ? 16'h9999 : r;
   endfunction

   // On a simultaneous respawn the hit belongs to the enemy that just left, held in pos_q
   always_comb begin
      rise = hit & ~hit_q;
      respawn = pos_s > pos_q;
      cpos = respawn ? pos_q : pos_s;
      perfect = cpos <= PERFECT_MAX;
      credit = rise & armed & ~credited & ~game_over & (cpos <= HIT_WINDOW);
      miss = respawn & armed & ~credited & ~credit & ~game_over;
      points = (perfect ? 3'd3 : 3'd1) + ((combo >= COMBO_BONUS_AT) ? 3'd1 : 3'd0);
      combo_n = (combo == 8'hff) ? combo : combo + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_m <= '0;
         pos_s <= '0;
         pos_q <= '0;
         hit_q <= 1'b0;
         credited <= 1'b0;
         armed <= 1'b0;
         cnt <= '0;
         score_bcd <= '0;
         combo <= '0;
         max_combo <= '0;
         lives <= LIVES;
         game_over <= 1'b0;
         judge_flag <= 2'd0;
      end else begin
         pos_m <= pos;
         pos_s <= pos_m;
         pos_q <= pos_s;
         hit_q <= hit;
         if (respawn) begin
            armed <= 1'b1;
            credited <= 1'b0;
         end else if (credit) credited <= 1'b1;
         if (credit) begin
            score_bcd <= bcd_add(score_bcd, points);
            combo <= combo_n;
            if (combo_n > max_combo) max_combo <= combo_n;
            judge_flag <= perfect ? 2'd2 : 2'd1;
            cnt <= LOAD;
         end else if (miss) begin
            combo <= '0;
            lives <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            game_over <= lives <= 3'd1;
            judge_flag <= 2'd3;
            cnt <= LOAD;
         end else if (judge_flag != 2'd0) begin
            if (cnt == '0) judge_flag <= 2'd0;
            else cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hit_scorer.sv
// tb_hit_scorer: directed scenario tasks for hit_scorer with hand-computed expectations
module tb_hit_scorer;
   logic clk = 1'b0, rst = 1'b0, hit = 1'b0;
   logic [3:0] pos = 4'd0;
   logic [15:0] score_bcd;
   logic [7:0] combo, max_combo;
   logic [2:0] lives;
   logic game_over;
   logic [1:0] judge_flag;
   int checks = 0, errs = 0;

   hit_scorer #(.FLAG_HOLD(8)) dut (
      .clk(clk), .rst(rst), .hit(hit), .pos(pos), .score_bcd(score_bcd), .combo(combo),
      .max_combo(max_combo), .lives(lives), .game_over(game_over), .judge_flag(judge_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic move(input logic [3:0] v);
      pos = v;
      repeat (4) tick();
   endtask

   task automatic pulse();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      tick();
   endtask

   task automatic enemy(input logic [3:0] p);
      move(4'd10);
      move(p);
      pulse();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hit = 1'b0;
      pos = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (score_bcd !== 16'h0000) begin errs++; $display("FAIL reset_score got %h want 0000", score_bcd); end
      checks++; if (combo !== 8'd0) begin errs++; $display("FAIL reset_combo got %0d want 0", combo); end
      checks++; if (max_combo !== 8'd0) begin errs++; $display("FAIL reset_max got %0d want 0", max_combo); end
      checks++; if (lives !== 3'd3) begin errs++; $display("FAIL reset_lives got %0d want 3", lives); end
      checks++; if (game_over !== 1'b0) begin errs++; $display("FAIL reset_go got %b want 0", game_over); end
      checks++; if (judge_flag !== 2'd0) begin errs++; $display("FAIL reset_flag got %0d want 0", judge_flag); end
      move(4'd10);
      checks++; if (lives !== 3'd3) begin errs++; $display("FAIL arm_lives got %0d want 3", lives); end
      checks++; if (judge_flag !== 2'd0) begin errs++; $display("FAIL arm_flag got %0d want 0", judge_flag); end
   endtask

   task automatic test_perfect();
      int n;
      move(4'd1);
      hit = 1'b1;
      tick();
      checks++; if (score_bcd !== 16'h0003) begin errs++; $display("FAIL perfect_score got %h want 0003", score_bcd); end
      checks++; if (combo !== 8'd1) begin errs++; $display("FAIL perfect_combo got %0d want 1", combo); end
      checks++; if (judge_flag !== 2'd2) begin errs++; $display("FAIL perfect_flag got %0d want 2", judge_flag); end
      n = 1;
      for (int i = 0; i < 20 && judge_flag == 2'd2; i++) begin
         hit = i < 4;
         tick();
         if (judge_flag == 2'd2) n++;
      end
      hit = 1'b0;
      checks++; if (n !== 8) begin errs++; $display("FAIL flag_hold got %0d cycles want 8", n); end
      checks++; if (judge_flag !== 2'd0) begin errs++; $display("FAIL flag_clear got %0d want 0", judge_flag); end
      checks++; if (combo !== 8'd1) begin errs++; $display("FAIL held_hit_combo got %0d want 1", combo); end
      move(4'd0);
      pulse();
      checks++; if (score_bcd !== 16'h0003) begin errs++; $display("FAIL second_hit_score got %h want 0003", score_bcd); end
      checks++; if (judge_flag !== 2'd0) begin errs++; $display("FAIL second_hit_flag got %0d want 0", judge_flag); end
   endtask

   task automatic test_good_early();
      move(4'd10);
      checks++; if (lives !== 3'd3) begin errs++; $display("FAIL credited_wrap_lives got %0d want 3", lives); end
      move(4'd5);
      pulse();
      checks++; if (score_bcd !== 16'h0003) begin errs++; $display("FAIL early_score got %h want 0003", score_bcd); end
      checks++; if (judge_flag !== 2'd0) begin errs++; $display("FAIL early_flag got %0d want 0", judge_flag); end
      move(4'd3);
      pulse();
      checks++; if (score_bcd !== 16'h0004) begin errs++; $display("FAIL good_score got %h want 0004", score_bcd); end
      checks++; if (combo !== 8'd2) begin errs++; $display("FAIL good_combo got %0d want 2", combo); end
      checks++; if (judge_flag !== 2'd1) begin errs++; $display("FAIL good_flag got %0d want 1", judge_flag); end
   endtask

   task automatic test_miss();
      enemy(4'd3);
      enemy(4'd3);
      checks++; if (combo !== 8'd4) begin errs++; $display("FAIL pre_miss_combo got %0d want 4", combo); end
      move(4'd10);
      move(4'd0);
      move(4'd10);
      checks++; if (combo !== 8'd0) begin errs++; $display("FAIL miss_combo got %0d want 0", combo); end
      checks++; if (max_combo !== 8'd4) begin errs++; $display("FAIL miss_max got %0d want 4", max_combo); end
      checks++; if (lives !== 3'd2) begin errs++; $display("FAIL miss_lives got %0d want 2", lives); end
      checks++; if (judge_flag !== 2'd3) begin errs++; $display("FAIL miss_flag got %0d want 3", judge_flag); end
      checks++; if (score_bcd !== 16'h0006) begin errs++; $display("FAIL miss_score got %h want 0006", score_bcd); end
   endtask

   task automatic test_combo_bcd();
      do_reset();
      repeat (10) enemy(4'd1);
      checks++; if (score_bcd !== 16'h0030) begin errs++; $display("FAIL ten_perfect got %h want 0030", score_bcd); end
      enemy(4'd1);
      checks++; if (score_bcd !== 16'h0034) begin errs++; $display("FAIL bonus_score got %h want 0034", score_bcd); end
      checks++; if (max_combo !== 8'd11) begin errs++; $display("FAIL bonus_max got %0d want 11", max_combo); end
      repeat (241) enemy(4'd1);
      checks++; if (score_bcd !== 16'h0998) begin errs++; $display("FAIL bcd_998 got %h want 0998", score_bcd); end
      move(4'd10);
      move(4'd0);
      move(4'd10);
      checks++; if (max_combo !== 8'd252) begin errs++; $display("FAIL long_max got %0d want 252", max_combo); end
      enemy(4'd1);
      checks++; if (score_bcd !== 16'h1001) begin errs++; $display("FAIL bcd_carry got %h want 1001", score_bcd); end
   endtask

   task automatic test_game_over();
      do_reset();
      move(4'd10);
      repeat (3) begin
         move(4'd0);
         move(4'd10);
      end
      checks++; if (lives !== 3'd0) begin errs++; $display("FAIL go_lives got %0d want 0", lives); end
      checks++; if (game_over !== 1'b1) begin errs++; $display("FAIL go_flag got %b want 1", game_over); end
      move(4'd1);
      pulse();
      checks++; if (score_bcd !== 16'h0000) begin errs++; $display("FAIL go_frozen_score got %h want 0000", score_bcd); end
      checks++; if (combo !== 8'd0) begin errs++; $display("FAIL go_frozen_combo got %0d want 0", combo); end
      move(4'd10);
      checks++; if (lives !== 3'd0) begin errs++; $display("FAIL go_no_underflow got %0d want 0", lives); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      move(4'd10);
      move(4'd1);
      pos = 4'd10;
      tick();
      tick();
      hit = 1'b1;
      tick();
      checks++; if (score_bcd !== 16'h0003) begin errs++; $display("FAIL simul_score got %h want 0003", score_bcd); end
      checks++; if (lives !== 3'd3) begin errs++; $display("FAIL simul_lives got %0d want 3", lives); end
      checks++; if (judge_flag !== 2'd2) begin errs++; $display("FAIL simul_flag got %0d want 2", judge_flag); end
      hit = 1'b0;
      tick();
      move(4'd0);
      move(4'd10);
      checks++; if (lives !== 3'd2) begin errs++; $display("FAIL new_enemy_uncredited got %0d want 2", lives); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      tick();
      checks++; if ({score_bcd, combo, max_combo, lives, game_over, judge_flag} !== {16'h0, 8'd0, 8'd0, 3'd3, 1'b0, 2'd0}) begin
         errs++;
         $display("FAIL reset_mid got %h/%0d/%0d/%0d/%b/%0d want 0000/0/0/3/0/0", score_bcd, combo, max_combo, lives, game_over, judge_flag);
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_perfect();
      test_good_early();
      test_miss();
      test_combo_bcd();
      test_game_over();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
